// File: rtl/nestop_altmemddr_0_ex_lfsr_gen.sv
// Galois LFSR pattern generator/checker for one DDR example-driver data lane.
// Define EX_LFSR_ERR_CAPTURE_EN to build the first-mismatch capture registers.
module nestop_altmemddr_0_ex_lfsr_gen #(
  parameter int                WIDTH = 8,
  parameter logic [WIDTH-1:0]  POLY  = WIDTH'(8'h1D),
  parameter logic [63:0]       SEED  = 64'd32,
  parameter int                CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             mode,
  input  logic             pause,
  input  logic             load,
  input  logic [WIDTH-1:0] ldata,
  output logic [WIDTH-1:0] data,
  input  logic             chk_valid,
  input  logic [WIDTH-1:0] chk_data,
  input  logic             err_clr,
  output logic             mismatch,
  output logic             err,
  output logic [CNT_W-1:0] err_cnt,
  output logic [WIDTH-1:0] cap_exp,
  output logic [WIDTH-1:0] cap_act
);

  // An all-zero seed would lock the LFSR up, so fall back to 1.
  localparam logic [WIDTH-1:0] SEED_RAW = WIDTH'(SEED);
  localparam logic [WIDTH-1:0] SEED_VAL = (SEED_RAW == '0) ? WIDTH'(1) : SEED_RAW;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN_GEN = 2'd1,
    RUN_CHK = 2'd2
  } state_t;

  state_t            state_reg, state_next;
  logic [WIDTH-1:0]  lfsr_reg, lfsr_next, step_val;
  logic              mismatch_reg;
  logic              err_reg, err_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic              cmp_fail;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= IDLE;
      lfsr_reg     <= SEED_VAL;
      mismatch_reg <= 1'b0;
      err_reg      <= 1'b0;
      cnt_reg      <= '0;
    end else begin
      state_reg    <= state_next;
      lfsr_reg     <= lfsr_next;
      mismatch_reg <= cmp_fail;
      err_reg      <= err_next;
      cnt_reg      <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    lfsr_next  = lfsr_reg;
    cmp_fail   = 1'b0;
    err_next   = err_reg;
    cnt_next   = cnt_reg;
    step_val   = {lfsr_reg[WIDTH-2:0], 1'b0} ^ (lfsr_reg[WIDTH-1] ? POLY : '0);

    case (state_reg)
      IDLE:    if (enable) state_next = mode ? RUN_CHK : RUN_GEN;
      RUN_GEN,
      RUN_CHK: if (!enable) state_next = IDLE;
      default: state_next = IDLE;
    endcase

    if (!enable || state_reg == IDLE) begin
      lfsr_next = SEED_VAL;
    end else if (load) begin
      lfsr_next = (ldata == '0) ? SEED_VAL : ldata;
    end else if (!pause && (state_reg == RUN_GEN || chk_valid)) begin
      lfsr_next = step_val;
    end

    // Compare against the word before this cycle's step.
    if (enable && state_reg == RUN_CHK && chk_valid && !pause && !load)
      cmp_fail = (chk_data != lfsr_reg);

    // Clear first so a simultaneous mismatch still counts as one.
    if (err_clr) begin
      err_next = 1'b0;
      cnt_next = '0;
    end
    if (cmp_fail) begin
      err_next = 1'b1;
      if (cnt_next != {CNT_W{1'b1}}) cnt_next = cnt_next + 1'b1;
    end
  end

  assign data     = lfsr_reg;
  assign mismatch = mismatch_reg;
  assign err      = err_reg;
  assign err_cnt  = cnt_reg;

`ifdef EX_LFSR_ERR_CAPTURE_EN
  logic [WIDTH-1:0] cap_exp_reg, cap_act_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cap_exp_reg <= '0;
      cap_act_reg <= '0;
    end else if (cmp_fail && (err_clr || !err_reg)) begin
      cap_exp_reg <= lfsr_reg;
      cap_act_reg <= chk_data;
    end else if (err_clr) begin
      cap_exp_reg <= '0;
      cap_act_reg <= '0;
    end
  end

  assign cap_exp = cap_exp_reg;
  assign cap_act = cap_act_reg;
`else
  assign cap_exp = '0;
  assign cap_act = '0;
`endif

endmodule

// File: tb/tb_nestop_altmemddr_0_ex_lfsr_gen.sv
// Directed table-driven bench for the LFSR pattern engine, plus hand-written
// sequences for maximal period, counter saturation and asynchronous reset.
module tb_nestop_altmemddr_0_ex_lfsr_gen;

`ifdef EX_LFSR_ERR_CAPTURE_EN
  localparam bit CAP = 1'b1;
`else
  localparam bit CAP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n;
  logic       enable, mode, pause, load, chk_valid, err_clr;
  logic [7:0] ldata, chk_data;

  logic [7:0]  data, cap_exp, cap_act;
  logic        mismatch, err;
  logic [15:0] err_cnt;

  logic [7:0]  data4, cap_exp4, cap_act4;
  logic        mismatch4, err4;
  logic [3:0]  err_cnt4;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  nestop_altmemddr_0_ex_lfsr_gen dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .mode(mode), .pause(pause),
    .load(load), .ldata(ldata), .data(data), .chk_valid(chk_valid),
    .chk_data(chk_data), .err_clr(err_clr), .mismatch(mismatch), .err(err),
    .err_cnt(err_cnt), .cap_exp(cap_exp), .cap_act(cap_act)
  );

  nestop_altmemddr_0_ex_lfsr_gen #(.CNT_W(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .enable(enable), .mode(mode), .pause(pause),
    .load(load), .ldata(ldata), .data(data4), .chk_valid(chk_valid),
    .chk_data(chk_data), .err_clr(err_clr), .mismatch(mismatch4), .err(err4),
    .err_cnt(err_cnt4), .cap_exp(cap_exp4), .cap_act(cap_act4)
  );

  typedef struct packed {
    logic        en, md, ps, ld;
    logic [7:0]  ldv;
    logic        cv;
    logic [7:0]  cd;
    logic        clr;
    logic [7:0]  e_data;
    logic        e_mm, e_err;
    logic [15:0] e_cnt;
    logic [7:0]  e_cexp, e_cact;
  } vec_t;

  localparam int NV = 25;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic en, md, ps, ld, input logic [7:0] ldv,
                              input logic cv, input logic [7:0] cd, input logic clr,
                              input logic [7:0] e_data, input logic e_mm, e_err,
                              input logic [15:0] e_cnt, input logic [7:0] e_cexp, e_cact);
    vec_t v;
    v.en = en; v.md = md; v.ps = ps; v.ld = ld; v.ldv = ldv; v.cv = cv; v.cd = cd;
    v.clr = clr; v.e_data = e_data; v.e_mm = e_mm; v.e_err = e_err; v.e_cnt = e_cnt;
    v.e_cexp = e_cexp; v.e_cact = e_cact;
    return v;
  endfunction

  function automatic logic [7:0] step(input logic [7:0] s);
    return {s[6:0], 1'b0} ^ (s[7] ? 8'h1D : 8'h00);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic apply(input logic en, md, ps, ld, input logic [7:0] ldv,
                       input logic cv, input logic [7:0] cd, input logic clr);
    enable = en; mode = md; pause = ps; load = ld; ldata = ldv;
    chk_valid = cv; chk_data = cd; err_clr = clr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [7:0] m;
    int         bad;

    // en md ps ld ldata cv cd clr | data mm err cnt cexp cact
    vecs[0]  = mk(1,0,0,0,8'h00,0,8'h00,0, 8'h20,0,0,0, 8'h00,8'h00);
    vecs[1]  = mk(1,0,0,0,8'h00,0,8'h00,0, 8'h40,0,0,0, 8'h00,8'h00);
    vecs[2]  = mk(1,0,0,0,8'h00,0,8'h00,0, 8'h80,0,0,0, 8'h00,8'h00);
    vecs[3]  = mk(1,0,0,0,8'h00,0,8'h00,0, 8'h1D,0,0,0, 8'h00,8'h00);
    vecs[4]  = mk(1,0,1,0,8'h00,0,8'h00,0, 8'h1D,0,0,0, 8'h00,8'h00);
    vecs[5]  = mk(1,0,0,1,8'h00,0,8'h00,0, 8'h20,0,0,0, 8'h00,8'h00);
    vecs[6]  = mk(1,0,1,1,8'h5A,0,8'h00,0, 8'h5A,0,0,0, 8'h00,8'h00);
    vecs[7]  = mk(0,0,0,0,8'h00,0,8'h00,0, 8'h20,0,0,0, 8'h00,8'h00);
    vecs[8]  = mk(0,0,0,0,8'h00,0,8'h00,0, 8'h20,0,0,0, 8'h00,8'h00);
    vecs[9]  = mk(1,1,0,0,8'h00,0,8'h00,0, 8'h20,0,0,0, 8'h00,8'h00);
    vecs[10] = mk(1,1,0,0,8'h00,1,8'h20,0, 8'h40,0,0,0, 8'h00,8'h00);
    vecs[11] = mk(1,1,0,0,8'h00,0,8'h00,0, 8'h40,0,0,0, 8'h00,8'h00);
    vecs[12] = mk(1,1,0,0,8'h00,1,8'h40,0, 8'h80,0,0,0, 8'h00,8'h00);
    vecs[13] = mk(1,1,0,0,8'h00,0,8'h00,0, 8'h80,0,0,0, 8'h00,8'h00);
    vecs[14] = mk(1,1,0,0,8'h00,1,8'h80,0, 8'h1D,0,0,0, 8'h00,8'h00);
    vecs[15] = mk(1,1,1,0,8'h00,1,8'h00,0, 8'h1D,0,0,0, 8'h00,8'h00);
    vecs[16] = mk(1,1,0,1,8'h1D,1,8'h00,0, 8'h1D,0,0,0, 8'h00,8'h00);
    vecs[17] = mk(1,1,0,0,8'h00,1,8'h1C,0, 8'h3A,1,1,1, 8'h1D,8'h1C);
    vecs[18] = mk(1,1,0,0,8'h00,0,8'h00,0, 8'h3A,0,1,1, 8'h1D,8'h1C);
    vecs[19] = mk(1,0,0,0,8'h00,1,8'h3A,0, 8'h74,0,1,1, 8'h1D,8'h1C);
    vecs[20] = mk(0,0,0,0,8'h00,0,8'h00,0, 8'h20,0,1,1, 8'h1D,8'h1C);
    vecs[21] = mk(0,0,0,0,8'h00,0,8'h00,1, 8'h20,0,0,0, 8'h00,8'h00);
    vecs[22] = mk(1,1,0,0,8'h00,0,8'h00,0, 8'h20,0,0,0, 8'h00,8'h00);
    vecs[23] = mk(1,1,0,0,8'h00,1,8'hFF,0, 8'h40,1,1,1, 8'h20,8'hFF);
    vecs[24] = mk(1,1,0,0,8'h00,1,8'h00,1, 8'h80,1,1,1, 8'h40,8'h00);

    reset_n = 1'b0;
    enable = 0; mode = 0; pause = 0; load = 0; ldata = 0;
    chk_valid = 0; chk_data = 0; err_clr = 0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_data", data, 8'h20);
    check("reset_mismatch", mismatch, 1'b0);
    check("reset_err", err, 1'b0);
    check("reset_cnt", err_cnt, 16'd0);
    check("reset_cap", {cap_exp, cap_act}, 16'h0000);
    #2 reset_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < NV; i++) begin
      apply(vecs[i].en, vecs[i].md, vecs[i].ps, vecs[i].ld, vecs[i].ldv,
            vecs[i].cv, vecs[i].cd, vecs[i].clr);
      $display("vec %0d: data=0x%02h mismatch=%0b err=%0b err_cnt=%0d cap=0x%02h/0x%02h",
               i, data, mismatch, err, err_cnt, cap_exp, cap_act);
      check($sformatf("vec%0d_data", i), data, vecs[i].e_data);
      check($sformatf("vec%0d_mismatch", i), mismatch, vecs[i].e_mm);
      check($sformatf("vec%0d_err", i), err, vecs[i].e_err);
      check($sformatf("vec%0d_cnt", i), err_cnt, vecs[i].e_cnt);
      check($sformatf("vec%0d_cap_exp", i), cap_exp, CAP ? vecs[i].e_cexp : 8'h00);
      check($sformatf("vec%0d_cap_act", i), cap_act, CAP ? vecs[i].e_cact : 8'h00);
    end

    // Asynchronous reset while a mismatch pulse and sticky error are live.
    apply(1,1,0,0,8'h00,1,8'h00,0);
    $display("pre-reset: data=0x%02h mismatch=%0b err=%0b err_cnt=%0d", data, mismatch, err, err_cnt);
    check("prereset_mismatch", mismatch, 1'b1);
    enable = 0; chk_valid = 0;
    reset_n = 1'b0;
    #1;
    $display("async reset: data=0x%02h mismatch=%0b err=%0b err_cnt=%0d", data, mismatch, err, err_cnt);
    check("areset_data", data, 8'h20);
    check("areset_mismatch", mismatch, 1'b0);
    check("areset_err", err, 1'b0);
    check("areset_cnt", err_cnt, 16'd0);
    check("areset_cnt4", err_cnt4, 4'd0);
    check("areset_cap", {cap_exp, cap_act}, 16'h0000);
    #1 reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Maximal period: 255 advances return to the seed and never hit zero.
    apply(1,0,0,0,8'h00,0,8'h00,0);
    check("period_start", data, 8'h20);
    m = 8'h20;
    bad = 0;
    for (int i = 0; i < 255; i++) begin
      apply(1,0,0,0,8'h00,0,8'h00,0);
      m = step(m);
      if (data !== m || data == 8'h00 || (i < 254 && data == 8'h20)) bad++;
    end
    $display("period: data=0x%02h after 255 advances, bad=%0d", data, bad);
    check("period_bad_steps", bad, 0);
    check("period_wrap", data, 8'h20);

    // Saturation of the 4-bit counter with 20 corrupt words.
    apply(0,0,0,0,8'h00,0,8'h00,1);
    apply(1,1,0,0,8'h00,0,8'h00,0);
    m = 8'h20;
    for (int i = 0; i < 20; i++) begin
      apply(1,1,0,0,8'h00,1,m ^ 8'h01,0);
      m = step(m);
    end
    $display("saturate: err_cnt4=%0d err_cnt=%0d err4=%0b data=0x%02h", err_cnt4, err_cnt, err4, data);
    check("sat_cnt4", err_cnt4, 4'd15);
    check("sat_err4", err4, 1'b1);
    check("sat_cnt16", err_cnt, 16'd20);
    check("sat_data", data4, m);

    apply(1,1,0,0,8'h00,1,m ^ 8'h01,1);
    m = step(m);
    $display("clr+mismatch: err_cnt4=%0d err4=%0b mismatch4=%0b", err_cnt4, err4, mismatch4);
    check("clrmm_cnt4", err_cnt4, 4'd1);
    check("clrmm_err4", err4, 1'b1);
    check("clrmm_mismatch4", mismatch4, 1'b1);
    check("clrmm_data", data4, m);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
